// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard slice:
// decoded ops, register index and queue entry.
package issue_scoreboard_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR,
    XOR, ADDI, ORI, ANDI,
    XORI, LD, SD, BEQ,
    LUI, AUIPC, JAL, JALR
  } decode_op_t;

  typedef struct packed {
    logic       valid;
    logic       wen;
    creg_addr_t rd;
  } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/flush bundle between the
// pipeline and the issue scoreboard.
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          dec_valid;
  decode_op_t    dec_op;
  creg_addr_t    dec_rs1;
  creg_addr_t    dec_rs2;
  creg_addr_t    dec_rd;
  logic          stall;
  logic          issue;
  logic          wb_valid;
  logic          flush;
  logic [CW-1:0] flush_keep;
  logic [CW-1:0] count;
  logic          err;

  modport master (
    output dec_valid, dec_op, dec_rs1,
    output dec_rs2, dec_rd, wb_valid,
    output flush, flush_keep,
    input  stall, issue, count, err
  );

  modport slave (
    input  dec_valid, dec_op, dec_rs1,
    input  dec_rs2, dec_rd, wb_valid,
    input  flush, flush_keep,
    output stall, issue, count, err
  );
endinterface

// File: rtl/issue_scoreboard_op_reg_use.sv
// Maps a decoded op to which register fields it
// reads and whether it writes rd.
module op_reg_use
  import issue_scoreboard_pkg::*;
(
  input  decode_op_t op,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       writes_rd
);

  always_comb begin
    use_rs1   = 1'b1;
    use_rs2   = 1'b1;
    writes_rd = 1'b1;
    unique case (op)
      ADDI, ORI, ANDI,
      XORI, LD, JALR: use_rs2 = 1'b0;
      SD, BEQ:        writes_rd = 1'b0;
      LUI, AUIPC, JAL: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order scoreboard: RAW/full stall for decode,
// retire on writeback, squash on flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  issue_scoreboard_if.slave sb
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW-1:0] head_n, tail_n;
  logic [PW-1:0] off [DEPTH];
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] rem, keep;
  logic [DEPTH-1:0] live_n;
  logic use1, use2, wrd;
  logic hazard, full, pop, err_q;

  op_reg_use u_use (
    .op        (sb.dec_op),
    .use_rs1   (use1),
    .use_rs2   (use2),
    .writes_rd (wrd)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && q[i].wen) begin
        if (use1 && sb.dec_rs1 != '0 &&
            sb.dec_rs1 == q[i].rd)
          hazard = 1'b1;
        if (use2 && sb.dec_rs2 != '0 &&
            sb.dec_rs2 == q[i].rd)
          hazard = 1'b1;
      end
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign pop   = sb.wb_valid & (count != '0);

  assign sb.stall = sb.dec_valid &
                    (hazard | full | sb.flush);
  assign sb.issue = sb.dec_valid & ~sb.stall;
  assign sb.count = count;
  assign sb.err   = err_q;

  // Pop first, then flush truncates what remains.
  always_comb begin
    head_n = head + PW'(pop);
    rem    = count - CW'(pop);
    keep   = (sb.flush_keep < rem) ?
             sb.flush_keep : rem;
    if (sb.flush) begin
      count_n = keep;
      tail_n  = head_n + keep[PW-1:0];
    end else begin
      count_n = rem + CW'(sb.issue);
      tail_n  = tail + PW'(sb.issue);
    end
  end

  // A slot is live iff it sits inside the new window.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i]    = PW'(i) - head_n;
      live_n[i] = {1'b0, off[i]} < count_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      err_q <= err_q |
               (sb.wb_valid & (count == '0));
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= live_n[i];
        if (sb.issue && PW'(i) == tail) begin
          q[i].wen <= wrd & (sb.dec_rd != '0);
          q[i].rd  <= sb.dec_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with
// hand-computed expectations.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  issue_scoreboard_if #(.DEPTH(4)) sb ();

  issue_scoreboard #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic dec(input logic v,
                     input decode_op_t op,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [4:0] rd);
    sb.dec_valid = v;
    sb.dec_op    = op;
    sb.dec_rs1   = rs1;
    sb.dec_rs2   = rs2;
    sb.dec_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    sb.wb_valid   = 1'b0;
    sb.flush      = 1'b0;
    sb.flush_keep = '0;
    dec(1'b0, ADD, 5'd0, 5'd0, 5'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", sb.count, 0);
    chk("rst_err", sb.err, 0);
    chk("rst_stall", sb.stall, 0);
    chk("rst_issue", sb.issue, 0);

    dec(1'b1, ADDI, 5'd1, 5'd0, 5'd5);
    #1;
    chk("addi_issue", sb.issue, 1);
    chk("addi_stall", sb.stall, 0);
    tick();
    chk("addi_count", sb.count, 1);

    dec(1'b1, ADD, 5'd5, 5'd2, 5'd6);
    #1;
    chk("raw_stall", sb.stall, 1);
    chk("raw_issue", sb.issue, 0);
    tick();
    chk("raw_hold_count", sb.count, 1);
    chk("raw_hold_stall", sb.stall, 1);
    sb.wb_valid = 1'b1;
    #1;
    chk("raw_no_bypass", sb.stall, 1);
    tick();
    sb.wb_valid = 1'b0;
    #1;
    chk("raw_pop_count", sb.count, 0);
    chk("raw_release", sb.issue, 1);
    tick();
    chk("add_count", sb.count, 1);
    sb.dec_valid = 1'b0;
    sb.wb_valid  = 1'b1;
    tick();
    sb.wb_valid = 1'b0;
    chk("drain1", sb.count, 0);

    dec(1'b1, LUI, 5'd0, 5'd0, 5'd3);
    tick();
    dec(1'b1, LUI, 5'd3, 5'd3, 5'd4);
    #1;
    chk("lui_no_use", sb.stall, 0);
    tick();
    chk("lui_count", sb.count, 2);
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd0);
    tick();
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd7);
    #1;
    chk("x0_no_haz", sb.stall, 0);
    tick();
    chk("full_count", sb.count, 4);

    dec(1'b1, ADDI, 5'd1, 5'd1, 5'd8);
    sb.wb_valid = 1'b1;
    #1;
    chk("full_stall", sb.stall, 1);
    chk("full_issue", sb.issue, 0);
    tick();
    sb.wb_valid = 1'b0;
    #1;
    chk("full_pop", sb.count, 3);
    chk("full_release", sb.issue, 1);
    tick();
    chk("refill", sb.count, 4);

    sb.dec_valid = 1'b0;
    sb.wb_valid  = 1'b1;
    repeat (4) tick();
    sb.wb_valid = 1'b0;
    chk("drain4", sb.count, 0);
    chk("drain_err", sb.err, 0);

    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd10);
    tick();
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd11);
    tick();
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd12);
    tick();
    chk("pre_flush", sb.count, 3);
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd13);
    sb.flush      = 1'b1;
    sb.flush_keep = 3'd1;
    sb.wb_valid   = 1'b1;
    #1;
    chk("flush_stall", sb.stall, 1);
    chk("flush_issue", sb.issue, 0);
    tick();
    sb.flush      = 1'b0;
    sb.flush_keep = '0;
    sb.wb_valid   = 1'b0;
    dec(1'b1, ADD, 5'd11, 5'd0, 5'd14);
    #1;
    chk("flush_count", sb.count, 1);
    chk("survivor", sb.stall, 1);
    dec(1'b1, ADD, 5'd12, 5'd0, 5'd14);
    #1;
    chk("dropped", sb.stall, 0);
    dec(1'b1, ADD, 5'd10, 5'd0, 5'd14);
    #1;
    chk("popped", sb.stall, 0);
    dec(1'b1, SD, 5'd0, 5'd11, 5'd0);
    #1;
    chk("sd_rs2", sb.stall, 1);
    dec(1'b1, ADDI, 5'd0, 5'd11, 5'd0);
    #1;
    chk("addi_rs2", sb.stall, 0);

    sb.dec_valid = 1'b0;
    sb.wb_valid  = 1'b1;
    tick();
    chk("last_pop", sb.count, 0);
    chk("no_err_yet", sb.err, 0);
    tick();
    sb.wb_valid = 1'b0;
    chk("underflow_err", sb.err, 1);
    chk("underflow_cnt", sb.count, 0);
    tick();
    chk("err_sticky", sb.err, 1);

    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd20);
    tick();
    dec(1'b1, ADDI, 5'd0, 5'd0, 5'd21);
    tick();
    chk("wrap_start", sb.count, 2);
    for (int k = 0; k < 10; k++) begin
      dec(1'b1, ADD, 5'(21 + k), 5'd0, 5'd0);
      #1;
      chk("wrap_live", sb.stall, 1);
      dec(1'b1, ADD, 5'(19 + k), 5'd0, 5'd0);
      #1;
      chk("wrap_dead", sb.stall, 0);
      dec(1'b1, ADDI, 5'd0, 5'd0, 5'(22 + k));
      sb.wb_valid = 1'b1;
      #1;
      chk("wrap_issue", sb.issue, 1);
      tick();
      sb.wb_valid = 1'b0;
      chk("wrap_count", sb.count, 2);
    end

    sb.dec_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_count", sb.count, 0);
    chk("async_err", sb.err, 0);
    reset = 1'b0;
    dec(1'b1, ADD, 5'd31, 5'd30, 5'd1);
    #1;
    chk("post_rst_iss", sb.issue, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
